// File: rtl/spike_generator.sv
// spike_generator: threshold/refractory stage of an FP32 LIF neuron.
// Compares the decayed potential with a threshold, emits spikes and the next-timestep potential.
`default_nettype none

module spike_generator #(
   parameter int REFRAC_W = 4
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                cfg_load,
   input  logic [31:0]         cfg_threshold,
   input  logic [31:0]         cfg_v_reset,
   input  logic [REFRAC_W-1:0] cfg_refractory,
   input  logic                potential_valid,
   input  logic [31:0]         potential_in,
   output logic                potential_ready,
   output logic [31:0]         potential_out,
   output logic                potential_out_valid,
   output logic                spike,
   output logic [15:0]         spike_count,
   output logic                refractory_active,
   output logic                nan_flag
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      EVAL   = 2'd1,
      REFRAC = 2'd2
   } state_t;

   state_t              state;
   logic [31:0]         latched;
   logic [31:0]         threshold;
   logic [31:0]         v_reset;
   logic [REFRAC_W-1:0] refrac_len;
   logic [REFRAC_W-1:0] refrac_cnt;
   logic                refrac_pend;
   logic                handshake;
   logic                latched_nan;
   logic                latched_ge;

   function automatic logic fp_is_nan(input logic [31:0] x);
      return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
   endfunction

   // Sign-magnitude ordering; both zeros compare equal regardless of sign.
   function automatic logic fp_ge(input logic [31:0] a, input logic [31:0] b);
      if ((a[30:0] == 31'd0) && (b[30:0] == 31'd0))
         return 1'b1;
      if (a[31] != b[31])
         return !a[31];
      if (!a[31])
         return a[30:0] >= b[30:0];
      return a[30:0] <= b[30:0];
   endfunction

   assign handshake         = potential_valid && potential_ready;
   assign potential_ready   = (state != EVAL);
   assign refractory_active = (state == REFRAC);
   assign latched_nan       = fp_is_nan(latched);
   assign latched_ge        = fp_ge(latched, threshold);

   always_ff @(posedge clock) begin
      if (reset) begin
         state               <= IDLE;
         latched             <= 32'd0;
         threshold           <= 32'h41F0_0000;
         v_reset             <= 32'd0;
         refrac_len          <= REFRAC_W'(2);
         refrac_cnt          <= '0;
         refrac_pend         <= 1'b0;
         potential_out       <= 32'd0;
         potential_out_valid <= 1'b0;
         spike               <= 1'b0;
         spike_count         <= 16'd0;
         nan_flag            <= 1'b0;
      end else begin
         spike               <= 1'b0;
         potential_out_valid <= 1'b0;

         // A refractory input is answered one cycle after its handshake so that
         // its latency matches the EVAL path.
         if (refrac_pend) begin
            refrac_pend         <= 1'b0;
            potential_out       <= v_reset;
            potential_out_valid <= 1'b1;
         end

         case (state)
            IDLE: begin
               if (cfg_load) begin
                  threshold  <= cfg_threshold;
                  v_reset    <= cfg_v_reset;
                  refrac_len <= cfg_refractory;
               end
               if (handshake) begin
                  latched <= potential_in;
                  state   <= EVAL;
               end
            end

            EVAL: begin
               potential_out_valid <= 1'b1;
               if (latched_nan) begin
                  nan_flag      <= 1'b1;
                  potential_out <= v_reset;
                  state         <= IDLE;
               end else if (latched_ge) begin
                  spike         <= 1'b1;
                  potential_out <= v_reset;
                  if (spike_count != 16'hFFFF)
                     spike_count <= spike_count + 16'd1;
                  refrac_cnt <= refrac_len;
                  state      <= (refrac_len != '0) ? REFRAC : IDLE;
               end else begin
                  potential_out <= latched;
                  state         <= IDLE;
               end
            end

            REFRAC: begin
               if (handshake) begin
                  refrac_pend <= 1'b1;
                  if (refrac_cnt != '0)
                     refrac_cnt <= refrac_cnt - REFRAC_W'(1);
                  if (refrac_cnt <= REFRAC_W'(1))
                     state <= IDLE;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire
